// File: rtl/ddr_init_sequencer.sv
// DDR4 channel bring-up sequencer.
// Holds every enabled channel's controller in reset, releases the channels one
// by one in ascending order with a fixed stagger, then waits for calibration
// under a timeout. Channels that miss the timeout are re-held and retried a
// bounded number of times; channels that run out of retries are marked failed.
// Ready channels are monitored continuously and flagged if calibration drops.
module ddr_init_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int RST_PULSE_CYC = 32,
    parameter int STAGGER_CYC   = 16,
    parameter int CAL_TIMEOUT   = 4096,
    parameter int MAX_RETRY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] cal_done,
    output logic [NUM_CH-1:0] ddr_rst,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_fail,
    output logic [NUM_CH-1:0] cal_lost,
    output logic              all_ready
);

    localparam int MAX_AB  = (RST_PULSE_CYC > STAGGER_CYC) ? RST_PULSE_CYC : STAGGER_CYC;
    localparam int MAX_CYC = (MAX_AB > CAL_TIMEOUT) ? MAX_AB : CAL_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int PW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(CAL_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HOLD     = 3'd1;
    localparam logic [2:0] S_RELEASE  = 3'd2;
    localparam logic [2:0] S_WAIT_CAL = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     ptr;
    logic [NUM_CH-1:0] ws;
    logic [NUM_CH-1:0] en_q;
    logic [2:0]        retry [NUM_CH];

    logic              accept;
    logic [NUM_CH-1:0] ready_mon;
    logic [NUM_CH-1:0] cal_hit;
    logic [NUM_CH-1:0] ws_left;
    logic [NUM_CH-1:0] can_retry;
    logic [PW-1:0]     lo_idx;
    logic              lo_has;
    logic              lo_more;
    logic [PW-1:0]     nx_idx;
    logic              nx_has;
    logic              nx_more;

    // Lowest set bit of mask at or above index 'from'.
    function automatic logic [PW-1:0] first_from(input logic [NUM_CH-1:0] mask, input int from);
        logic [PW-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = PW'(i);
        end
        return r;
    endfunction

    // True when mask has any set bit at or above index 'from'.
    function automatic logic has_from(input logic [NUM_CH-1:0] mask, input int from);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i] && (i >= from)) r = 1'b1;
        end
        return r;
    endfunction

    assign busy      = (state == S_HOLD) || (state == S_RELEASE) || (state == S_WAIT_CAL);
    assign all_ready = ((ch_ready & en_q) == en_q);

    // Start acceptance, calibration hits, channel scan and retry eligibility.
    always_comb begin
        accept    = start && ((state == S_IDLE) || (state == S_DONE));
        ready_mon = ch_ready & cal_done;
        cal_hit   = ws & ~ddr_rst & cal_done;
        ws_left   = ws & ~cal_hit;
        lo_has    = |ws;
        lo_idx    = first_from(ws, 0);
        lo_more   = has_from(ws, int'(lo_idx) + 1);
        nx_has    = has_from(ws, int'(ptr) + 1);
        nx_idx    = first_from(ws, int'(ptr) + 1);
        nx_more   = has_from(ws, int'(nx_idx) + 1);
        can_retry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            can_retry[i] = (retry[i] < RETRY_LIM);
        end
    end

    // Sequencer FSM, counters, per-channel reset and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            ws       <= '0;
            en_q     <= '0;
            ddr_rst  <= '1;
            ch_ready <= '0;
            ch_fail  <= '0;
            cal_lost <= '0;
            done     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) retry[i] <= '0;
        end else begin
            done     <= 1'b0;
            ch_ready <= ready_mon;
            cal_lost <= cal_lost | (ch_ready & ~cal_done);
            cnt      <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

            if (accept) begin
                en_q     <= ch_enable;
                ws       <= ch_enable;
                ch_fail  <= '0;
                ch_ready <= '0;
                cal_lost <= '0;
                ddr_rst  <= '1;
                cnt      <= '0;
                for (int i = 0; i < NUM_CH; i++) retry[i] <= '0;
                if (ch_enable == '0) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state <= S_HOLD;
                end
            end else begin
                case (state)
                    S_IDLE, S_DONE: ;
                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            if (lo_has) begin
                                ddr_rst[lo_idx] <= 1'b0;
                                ptr             <= lo_idx;
                                cnt             <= '0;
                                state           <= lo_more ? S_RELEASE : S_WAIT_CAL;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (cnt == STAG_LAST) begin
                            cnt <= '0;
                            if (nx_has) begin
                                ddr_rst[nx_idx] <= 1'b0;
                                ptr             <= nx_idx;
                                state           <= nx_more ? S_RELEASE : S_WAIT_CAL;
                            end else begin
                                state <= S_WAIT_CAL;
                            end
                        end
                    end
                    S_WAIT_CAL: begin
                        ch_ready <= ready_mon | cal_hit;
                        ws       <= ws_left;
                        if (ws_left == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cnt == TO_LAST) begin
                            ws      <= ws_left & can_retry;
                            ch_fail <= ch_fail | (ws_left & ~can_retry);
                            ddr_rst <= ddr_rst | ws_left;
                            cnt     <= '0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ws_left[i] && can_retry[i]) retry[i] <= retry[i] + 3'd1;
                            end
                            if ((ws_left & can_retry) == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_HOLD;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
